mcpu_sequencer: RTL and testbench
=================================

# mcpu_sequencer

Parametrised control sequencer for the next-generation multi-cycle CPU: owns PC, IR and the main FSM, and drives all datapath enables and mux selects. Unlike the current hard-wired zero-wait control LUT, it handles a ready-based memory handshake with wait states, has a bounded-wait timeout, and computes next-PC internally (branch, J, JAL, JR). A sticky fault state catches illegal opcodes and memory timeouts. It sits between the unified instruction/data memory and the regfile/ALU datapath.

## Interface
- XLEN, 32: PC/data width (≥32; instruction always 32 bits)
- RESET_PC, 0: PC value loaded at reset
- TIMEOUT, 15: maximum wait cycles per memory request before fault (1..255)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_rdata  in  32  memory read data (instruction fetch)
- mem_ready  in  1  memory completes current request this cycle
- alu_zero  in  1  ALU zero flag, valid in BRANCH state
- rs_data  in  XLEN  regfile port-1 data, JR target
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALU register
- pc  out  XLEN  program counter
- ir  out  32  instruction register
- ab_we, mdr_we, aluout_we  out  1 each  datapath register enables
- reg_we  out  1  regfile write enable
- reg_dst  out  2  0 = rd, 1 = rt, 2 = $31
- wb_sel  out  2  0 = ALU register, 1 = MDR, 2 = PC
- alu_srcb  out  1  0 = B register, 1 = sign-extended imm (zero-extended for XORI)
- alu_op  out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT
- fault  out  1  sticky fault flag
- fault_code  out  2  0 none, 1 illegal opcode, 2 memory timeout

## Operation
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, JR, FAULT.
- RST: all outputs 0; entered asynchronously on reset low; next edge after release → FETCH.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ready: ir←mem_rdata, pc←pc+4, → DECODE.
- DECODE: ab_we=1; classify ir[31:26] (funct ir[5:0] for op 0).
  - R ADD/SUB/SLT → EXEC_R; JR (funct 0x08) → JR
  - ADDI 0x08 / XORI 0x0E → EXEC_I; LW 0x23 / SW 0x2B → ADDR
  - BEQ 0x04 / BNE 0x05 → BRANCH; J 0x02 / JAL 0x03 → JUMP
  - anything else → FAULT, code 1
- EXEC_R/EXEC_I: alu_op per instruction, aluout_we=1 → WB_ALU. WB_ALU: reg_we=1, reg_dst=0 (R) or 1 (I), wb_sel=0 → FETCH.
- ADDR: alu_srcb=1, ADD, aluout_we=1 → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_req=1, sel=1; on ready mdr_we=1 → WB_MEM. WB_MEM: reg_we, reg_dst=1, wb_sel=1 → FETCH.
- MEM_WR: mem_req=1, mem_we=1, sel=1; on ready → FETCH.
- BRANCH: alu_op=SUB; taken when alu_zero==1 (BEQ) or 0 (BNE); taken: pc←pc+(sext(imm16)<<2) (pc already +4) → FETCH.
- JUMP: pc←{pc[XLEN-1:28], ir[25:0], 2'b00}; JAL also reg_we, reg_dst=2, wb_sel=2 (writes old pc = return addr) → FETCH.
- JR: pc←rs_data → FETCH.
- FAULT: all enables/req 0; held until reset.
- Timeout: wait counter clears on state entry; increments every request cycle without mem_ready; reaching TIMEOUT without ready → FAULT, code 2. Ready on the TIMEOUT-th cycle is accepted.
- Arithmetic in XLEN bits, wrap modulo 2^XLEN; no overflow trap.

## Timing
- Reset values: state RST, pc=RESET_PC, ir=0, fault=0, fault_code=0, all control outputs 0.
- Control outputs are Moore (state) plus a mem_ready qualifier for mdr_we; pc/ir registered.
- Zero-wait cycle counts: R/ADDI/XORI 4, LW 5, SW 4, BEQ/BNE/J/JAL/JR 3; each memory wait cycle adds 1.
- mem_ready in the first request cycle completes it (no minimum wait); mem_ready outside request states is ignored.
- Reset low mid-request: mem_req drops asynchronously; no partial IR/PC update.

## Structure
- Shared package mcpu_pkg: opcode/funct constants, ALU command codes, state enum, reg_dst/wb_sel/fault_code encodings.
- One sub-module, mcpu_decode: combinational ir → instruction class plus illegal flag; FSM, counter and PC logic stay in mcpu_sequencer.

## Test plan
- Reset release, ADD $3,$1,$2 at PC 0, ready immediate → FETCH,DECODE,EXEC_R,WB_ALU; reg_we in cycle 4, reg_dst=0; pc=4.
- LW with 3 wait cycles in MEM_RD → 8 cycles total; mdr_we only on the ready cycle; WB_MEM reg_dst=1, wb_sel=1.
- BNE at pc 0x10, imm=-2, alu_zero=0 → pc=0x0C; same with alu_zero=1 → pc=0x14.
- JAL addr 0x40 at pc 0x100 → $31 written with 0x104 (reg_dst=2, wb_sel=2), pc=0x100.
- Opcode 0x3F → FAULT, fault_code=1; no mem_req until reset; TIMEOUT=4 with ready withheld in FETCH → FAULT after 4 cycles, code 2.
- Reset asserted in the second wait cycle of MEM_WR → mem_req=0 immediately, pc=RESET_PC, and FETCH one cycle after release.

Source files
------------

// File: rtl/mcpu_pkg.sv
// +----------------------------------------------------------------+
// | mcpu_pkg : shared encodings for the multi-cycle CPU sequencer  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

package mcpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JR, S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    DST_RD = 2'd0,
    DST_RT = 2'd1,
    DST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ILLEGAL = 2'd1,
    FC_TIMEOUT = 2'd2
  } fault_code_e;

  typedef enum logic [3:0] {
    IC_ALU_R, IC_JR, IC_ALU_I, IC_LW, IC_SW,
    IC_BEQ, IC_BNE, IC_J, IC_JAL, IC_ILLEGAL
  } iclass_e;

endpackage

`default_nettype wire

// File: rtl/mcpu_decode.sv
// +----------------------------------------------------------------+
// | mcpu_decode : opcode/funct -> instruction class and ALU op     |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module mcpu_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o,
  output alu_op_e    alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o    = IC_ILLEGAL;
    alu_op_o = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  cls_o = IC_ALU_R;
          FN_SUB:  begin cls_o = IC_ALU_R; alu_op_o = ALU_SUB; end
          FN_SLT:  begin cls_o = IC_ALU_R; alu_op_o = ALU_SLT; end
          FN_JR:   cls_o = IC_JR;
          default: cls_o = IC_ILLEGAL;
        endcase
      end
      OP_ADDI: cls_o = IC_ALU_I;
      OP_XORI: begin cls_o = IC_ALU_I; alu_op_o = ALU_XOR; end
      OP_LW:   cls_o = IC_LW;
      OP_SW:   cls_o = IC_SW;
      OP_BEQ:  cls_o = IC_BEQ;
      OP_BNE:  cls_o = IC_BNE;
      OP_J:    cls_o = IC_J;
      OP_JAL:  cls_o = IC_JAL;
      default: cls_o = IC_ILLEGAL;
    endcase
  end

  assign illegal_o = (cls_o == IC_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/mcpu_sequencer.sv
// +----------------------------------------------------------------+
// | mcpu_sequencer : PC/IR owner and main control FSM of the CPU   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module mcpu_sequencer
  import mcpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 15
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [31:0]     mem_rdata_i,
  input  logic            mem_ready_i,
  input  logic            alu_zero_i,
  input  logic [XLEN-1:0] rs_data_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            mem_addr_sel_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     ir_o,
  output logic            ab_we_o,
  output logic            mdr_we_o,
  output logic            aluout_we_o,
  output logic            reg_we_o,
  output logic [1:0]      reg_dst_o,
  output logic [1:0]      wb_sel_o,
  output logic            alu_srcb_o,
  output logic [2:0]      alu_op_o,
  output logic            fault_o,
  output logic [1:0]      fault_code_o
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [7:0]      wait_q, wait_d;
  logic            fault_q, fault_d;
  fault_code_e     fcode_q, fcode_d;

  iclass_e         w_cls;
  alu_op_e         w_alu_op;
  logic            w_illegal;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_j_target;

  mcpu_decode u_decode (
    .op_i      (ir_q[31:26]),
    .funct_i   (ir_q[5:0]),
    .cls_o     (w_cls),
    .alu_op_o  (w_alu_op),
    .illegal_o (w_illegal)
  );

  // pc_q already points at the next instruction when these are used.
  assign w_br_target = pc_q + {{(XLEN-18){ir_q[15]}}, ir_q[15:0], 2'b00};
  assign w_j_target  = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    wait_d         = '0;
    fault_d        = fault_q;
    fcode_d        = fcode_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ab_we_o        = 1'b0;
    mdr_we_o       = 1'b0;
    aluout_we_o    = 1'b0;
    reg_we_o       = 1'b0;
    reg_dst_o      = DST_RD;
    wb_sel_o       = WB_ALUOUT;
    alu_srcb_o     = 1'b0;
    alu_op_o       = ALU_ADD;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we_o = 1'b1;
        if (w_illegal) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          fcode_d = FC_ILLEGAL;
        end else begin
          case (w_cls)
            IC_ALU_R:      state_d = S_EXEC_R;
            IC_ALU_I:      state_d = S_EXEC_I;
            IC_LW, IC_SW:  state_d = S_ADDR;
            IC_BEQ, IC_BNE: state_d = S_BRANCH;
            IC_J, IC_JAL:  state_d = S_JUMP;
            IC_JR:         state_d = S_JR;
            default:       state_d = S_FAULT;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_op_o    = w_alu_op;
        aluout_we_o = 1'b1;
        state_d     = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_op_o    = w_alu_op;
        alu_srcb_o  = 1'b1;
        aluout_we_o = 1'b1;
        state_d     = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_we_o  = 1'b1;
        reg_dst_o = (w_cls == IC_ALU_R) ? DST_RD : DST_RT;
        wb_sel_o  = WB_ALUOUT;
        state_d   = S_FETCH;
      end
      S_ADDR: begin
        alu_srcb_o  = 1'b1;
        alu_op_o    = ALU_ADD;
        aluout_we_o = 1'b1;
        state_d     = (w_cls == IC_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        if (mem_ready_i) begin
          mdr_we_o = 1'b1;
          state_d  = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        reg_we_o  = 1'b1;
        reg_dst_o = DST_RT;
        wb_sel_o  = WB_MDR;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_o      = 1'b1;
        mem_we_o       = 1'b1;
        mem_addr_sel_o = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_op_o = ALU_SUB;
        if ((w_cls == IC_BEQ && alu_zero_i) || (w_cls == IC_BNE && !alu_zero_i))
          pc_d = w_br_target;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d = w_j_target;
        // JAL writes the incremented PC, i.e. the return address.
        if (w_cls == IC_JAL) begin
          reg_we_o  = 1'b1;
          reg_dst_o = DST_RA;
          wb_sel_o  = WB_PC;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_d    = rs_data_i;
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RST;
    endcase
    // An unanswered request is fatal once it has waited TIMEOUT cycles.
    if (mem_req_o && !mem_ready_i) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
        fcode_d = FC_TIMEOUT;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
      fcode_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      fcode_q <= fcode_d;
    end
  end

  assign pc_o         = pc_q;
  assign ir_o         = ir_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fcode_q;

endmodule

`default_nettype wire

// File: tb/tb_mcpu_sequencer.sv
// +----------------------------------------------------------------+
// | tb_mcpu_sequencer : randomized self-checking bench             |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module tb_mcpu_sequencer;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     mem_rdata_i = '0;
  logic            mem_ready_i = 1'b0;
  logic            alu_zero_i = 1'b0;
  logic [XLEN-1:0] rs_data_i = '0;
  logic            mem_req_o, mem_we_o, mem_addr_sel_o;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     ir_o;
  logic            ab_we_o, mdr_we_o, aluout_we_o, reg_we_o;
  logic [1:0]      reg_dst_o, wb_sel_o;
  logic            alu_srcb_o;
  logic [2:0]      alu_op_o;
  logic            fault_o;
  logic [1:0]      fault_code_o;

  int n_cmp = 0;
  int n_fail = 0;

  wire [14:0] ctl = {mem_req_o, mem_we_o, mem_addr_sel_o, ab_we_o, mdr_we_o,
                     aluout_we_o, reg_we_o, reg_dst_o, wb_sel_o, alu_srcb_o, alu_op_o};

  mcpu_sequencer #(.XLEN(XLEN), .RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .alu_zero_i(alu_zero_i), .rs_data_i(rs_data_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_sel_o(mem_addr_sel_o), .pc_o(pc_o), .ir_o(ir_o), .ab_we_o(ab_we_o),
    .mdr_we_o(mdr_we_o), .aluout_we_o(aluout_we_o), .reg_we_o(reg_we_o), .reg_dst_o(reg_dst_o),
    .wb_sel_o(wb_sel_o), .alu_srcb_o(alu_srcb_o), .alu_op_o(alu_op_o), .fault_o(fault_o),
    .fault_code_o(fault_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        done;
    int          cycles;
    int          regwes;
    logic [1:0]  dst;
    logic [1:0]  wsel;
    logic [31:0] wbval;
    int          mdrs;
    logic        mdr_bad;
    logic        has_alu;
    logic [2:0]  aluop;
    logic        srcb;
    int          wes;
    logic [31:0] npc;
  } rec_t;

  task automatic tick(input logic rdy);
    mem_ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0);
    rst_n = 1'b1;
    tick(1'b0);
  endtask

  // Executes one instruction starting in its first FETCH cycle; returns when the next fetch begins.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z,
                           input logic [31:0] rs, output rec_t o);
    int   reqn;
    logic fetched;
    logic rdy;
    o = '0;
    reqn = 0;
    fetched = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req_o && !mem_addr_sel_o && fetched) begin
        o.done = 1'b1;
        break;
      end
      o.cycles++;
      if (mem_req_o) begin
        rdy  = (reqn >= (mem_addr_sel_o ? mw : fw));
        reqn = rdy ? 0 : reqn + 1;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      mem_rdata_i = ins;
      alu_zero_i  = z;
      rs_data_i   = rs;
      mem_ready_i = rdy;
      #1;
      if (reg_we_o) begin o.regwes++; o.dst = reg_dst_o; o.wsel = wb_sel_o; o.wbval = pc_o; end
      if (mdr_we_o) begin o.mdrs++; if (!rdy) o.mdr_bad = 1'b1; end
      if (aluout_we_o) begin o.has_alu = 1'b1; o.aluop = alu_op_o; o.srcb = alu_srcb_o; end
      if (mem_we_o) o.wes++;
      if (mem_req_o && !mem_addr_sel_o && rdy) fetched = 1'b1;
      @(posedge clk_i);
      #1;
    end
    o.npc = pc_o;
  endtask

  // Instruction-level reference: what one instruction should do, from the ISA rules.
  function automatic rec_t model(input logic [31:0] ins, input int fw, input int mw,
                                 input logic z, input logic [31:0] rs, input logic [31:0] pc);
    rec_t        e;
    logic [31:0] p4;
    logic [31:0] boff;
    e      = '0;
    e.done = 1'b1;
    p4     = pc + 32'd4;
    boff   = {{14{ins[15]}}, ins[15:0], 2'b00};
    e.npc  = p4;
    e.cycles = 1 + fw;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] == 6'h08) begin
          e.cycles += 2; e.npc = rs;
        end else begin
          e.cycles += 3; e.regwes = 1; e.dst = 2'd0; e.wsel = 2'd0; e.has_alu = 1'b1;
          e.aluop = (ins[5:0] == 6'h22) ? 3'd1 : (ins[5:0] == 6'h2A) ? 3'd3 : 3'd0;
        end
      end
      6'h08, 6'h0E: begin
        e.cycles += 3; e.regwes = 1; e.dst = 2'd1; e.wsel = 2'd0; e.has_alu = 1'b1; e.srcb = 1'b1;
        e.aluop = (ins[31:26] == 6'h0E) ? 3'd2 : 3'd0;
      end
      6'h23: begin
        e.cycles += 4 + mw; e.regwes = 1; e.dst = 2'd1; e.wsel = 2'd1; e.mdrs = 1;
        e.has_alu = 1'b1; e.srcb = 1'b1;
      end
      6'h2B: begin
        e.cycles += 3 + mw; e.wes = mw + 1; e.has_alu = 1'b1; e.srcb = 1'b1;
      end
      6'h04: begin e.cycles += 2; if (z) e.npc = p4 + boff; end
      6'h05: begin e.cycles += 2; if (!z) e.npc = p4 + boff; end
      6'h02: begin e.cycles += 2; e.npc = {p4[31:28], ins[25:0], 2'b00}; end
      default: begin
        e.cycles += 2; e.npc = {p4[31:28], ins[25:0], 2'b00};
        e.regwes = 1; e.dst = 2'd2; e.wsel = 2'd2; e.wbval = p4;
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen_instr(input int k, input logic [31:0] r);
    case (k)
      0:  return {6'h00, r[25:6], 6'h20};
      1:  return {6'h00, r[25:6], 6'h22};
      2:  return {6'h00, r[25:6], 6'h2A};
      3:  return {6'h00, r[25:6], 6'h08};
      4:  return {6'h08, r[25:0]};
      5:  return {6'h0E, r[25:0]};
      6:  return {6'h23, r[25:0]};
      7:  return {6'h2B, r[25:0]};
      8:  return {6'h04, r[25:0]};
      9:  return {6'h05, r[25:0]};
      10: return {6'h02, r[25:0]};
      default: return {6'h03, r[25:0]};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b1);
    n_cmp++; if (ctl !== 15'd0) begin n_fail++; $display("FAIL reset_ctl: got %0h expected 0", ctl); end
    n_cmp++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", pc_o); end
    n_cmp++; if (ir_o !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %0h expected 0", ir_o); end
    n_cmp++; if ({fault_o, fault_code_o} !== 3'd0) begin n_fail++; $display("FAIL reset_fault: got %0h expected 0", {fault_o, fault_code_o}); end
    rst_n = 1'b1;
    n_cmp++; if (ctl !== 15'd0) begin n_fail++; $display("FAIL rst_state_ctl: got %0h expected 0", ctl); end
    tick(1'b1);
    n_cmp++; if ({mem_req_o, mem_addr_sel_o} !== 2'b10) begin n_fail++; $display("FAIL first_fetch: got %0b expected 10", {mem_req_o, mem_addr_sel_o}); end
  endtask

  task automatic test_directed();
    rec_t o;
    run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 0, 0, 1'b0, 32'h0, o);
    n_cmp++; if (o.cycles !== 4) begin n_fail++; $display("FAIL add_cycles: got %0d expected 4", o.cycles); end
    n_cmp++; if ({o.regwes[1:0], o.dst, o.wsel} !== 6'b01_00_00) begin n_fail++; $display("FAIL add_wb: got %0b expected 010000", {o.regwes[1:0], o.dst, o.wsel}); end
    n_cmp++; if (o.npc !== 32'h4) begin n_fail++; $display("FAIL add_pc: got %0h expected 4", o.npc); end
    run_instr({6'h23, 5'd1, 5'd2, 16'h0010}, 0, 3, 1'b0, 32'h0, o);
    n_cmp++; if (o.cycles !== 8) begin n_fail++; $display("FAIL lw_cycles: got %0d expected 8", o.cycles); end
    n_cmp++; if ({o.mdrs[1:0], o.mdr_bad} !== 3'b010) begin n_fail++; $display("FAIL lw_mdr: got %0b expected 010", {o.mdrs[1:0], o.mdr_bad}); end
    n_cmp++; if ({o.dst, o.wsel} !== 4'b01_01) begin n_fail++; $display("FAIL lw_wb: got %0b expected 0101", {o.dst, o.wsel}); end
    run_instr({6'h02, 26'h4}, 0, 0, 1'b0, 32'h0, o);
    run_instr({6'h05, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0, 32'h0, o);
    n_cmp++; if (o.npc !== 32'h0C || o.cycles !== 3) begin n_fail++; $display("FAIL bne_taken: got pc %0h cyc %0d expected pc c cyc 3", o.npc, o.cycles); end
    run_instr({6'h02, 26'h4}, 0, 0, 1'b0, 32'h0, o);
    run_instr({6'h05, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b1, 32'h0, o);
    n_cmp++; if (o.npc !== 32'h14) begin n_fail++; $display("FAIL bne_not_taken: got %0h expected 14", o.npc); end
    run_instr({6'h02, 26'h40}, 0, 0, 1'b0, 32'h0, o);
    run_instr({6'h03, 26'h40}, 0, 0, 1'b0, 32'h0, o);
    n_cmp++; if (o.wbval !== 32'h104) begin n_fail++; $display("FAIL jal_ret: got %0h expected 104", o.wbval); end
    n_cmp++; if ({o.regwes[1:0], o.dst, o.wsel} !== 6'b01_10_10) begin n_fail++; $display("FAIL jal_wb: got %0b expected 011010", {o.regwes[1:0], o.dst, o.wsel}); end
    n_cmp++; if (o.npc !== 32'h100) begin n_fail++; $display("FAIL jal_pc: got %0h expected 100", o.npc); end
  endtask

  task automatic test_random();
    rec_t        o, e;
    logic [31:0] ins, rs, mpc;
    int          fw, mw;
    logic        z;
    mpc = 32'h100;
    for (int i = 0; i < 60; i++) begin
      ins = gen_instr($urandom_range(0, 11), $urandom);
      fw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 3);
      z   = 1'($urandom_range(0, 1));
      rs  = $urandom;
      e   = model(ins, fw, mw, z, rs, mpc);
      run_instr(ins, fw, mw, z, rs, o);
      n_cmp++; if (o.done !== 1'b1) begin n_fail++; $display("FAIL rnd_done[%0d]: got %0b expected 1", i, o.done); end
      n_cmp++; if (o.cycles !== e.cycles) begin n_fail++; $display("FAIL rnd_cycles[%0d] ins %0h: got %0d expected %0d", i, ins, o.cycles, e.cycles); end
      n_cmp++; if (o.npc !== e.npc) begin n_fail++; $display("FAIL rnd_pc[%0d] ins %0h: got %0h expected %0h", i, ins, o.npc, e.npc); end
      n_cmp++; if (ir_o !== ins) begin n_fail++; $display("FAIL rnd_ir[%0d]: got %0h expected %0h", i, ir_o, ins); end
      n_cmp++; if (o.regwes !== e.regwes) begin n_fail++; $display("FAIL rnd_regwe[%0d] ins %0h: got %0d expected %0d", i, ins, o.regwes, e.regwes); end
      if (e.regwes == 1) begin
        n_cmp++; if ({o.dst, o.wsel} !== {e.dst, e.wsel}) begin n_fail++; $display("FAIL rnd_wbsel[%0d] ins %0h: got %0b expected %0b", i, ins, {o.dst, o.wsel}, {e.dst, e.wsel}); end
      end
      if (e.wsel == 2'd2) begin
        n_cmp++; if (o.wbval !== e.wbval) begin n_fail++; $display("FAIL rnd_ret[%0d]: got %0h expected %0h", i, o.wbval, e.wbval); end
      end
      n_cmp++; if ({o.mdrs, o.mdr_bad} !== {e.mdrs, 1'b0}) begin n_fail++; $display("FAIL rnd_mdr[%0d]: got %0d/%0b expected %0d/0", i, o.mdrs, o.mdr_bad, e.mdrs); end
      n_cmp++; if (o.wes !== e.wes) begin n_fail++; $display("FAIL rnd_memwe[%0d]: got %0d expected %0d", i, o.wes, e.wes); end
      n_cmp++; if (o.has_alu !== e.has_alu) begin n_fail++; $display("FAIL rnd_aluwe[%0d] ins %0h: got %0b expected %0b", i, ins, o.has_alu, e.has_alu); end
      if (e.has_alu) begin
        n_cmp++; if ({o.aluop, o.srcb} !== {e.aluop, e.srcb}) begin n_fail++; $display("FAIL rnd_aluop[%0d] ins %0h: got %0h expected %0h", i, ins, {o.aluop, o.srcb}, {e.aluop, e.srcb}); end
      end
      mpc = e.npc;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    int          viol;
    bad[0] = 32'hFC00_0000;
    bad[1] = 32'h0022_1821;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      mem_rdata_i = bad[k];
      tick(1'b1);
      tick(1'b0);
      n_cmp++; if ({fault_o, fault_code_o} !== 3'b101) begin n_fail++; $display("FAIL illegal_fault[%0d]: got %0b expected 101", k, {fault_o, fault_code_o}); end
      viol = 0;
      for (int c = 0; c < 8; c++) begin
        tick(1'($urandom_range(0, 1)));
        if (ctl !== 15'd0 || fault_o !== 1'b1) viol++;
      end
      n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL illegal_hold[%0d]: got %0d active cycles expected 0", k, viol); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    n_cmp++; if ({mem_req_o, fault_o} !== 2'b10) begin n_fail++; $display("FAIL timeout_early: got %0b expected 10", {mem_req_o, fault_o}); end
    tick(1'b0);
    n_cmp++; if ({fault_o, fault_code_o, mem_req_o} !== 4'b1100) begin n_fail++; $display("FAIL timeout_fault: got %0b expected 1100", {fault_o, fault_code_o, mem_req_o}); end
  endtask

  task automatic test_reset_mid_request();
    do_reset();
    mem_rdata_i = {6'h2B, 5'd1, 5'd2, 16'h0010};
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_sel_o, pc_o} !== {3'b111, 32'h4}) begin n_fail++; $display("FAIL midreq_pre: got %0h expected 700000004", {mem_req_o, mem_we_o, mem_addr_sel_o, pc_o}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL midreq_req_drop: got %0b expected 0", mem_req_o); end
    n_cmp++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL midreq_pc: got %0h expected 0", pc_o); end
    #2;
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    n_cmp++; if ({mem_req_o, mem_addr_sel_o, pc_o} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL midreq_refetch: got %0h expected 200000000", {mem_req_o, mem_addr_sel_o, pc_o}); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
